inst_loader: RTL and testbench
==============================

// Module: inst_loader
// PURPOSE
//  Writer side of the core's instruction memory: accepts a stream of 9-bit
//  instruction words over valid/ready, writes them to consecutive imem
//  addresses from 0, then releases the core's active-high start, times the
//  run until core halt, and reports done/error.
//  Sits between the testbench/host link and TopLevel (imem write port + start/halt).
// PARAMETERS
//  IW          9      instruction word width
//  AW          10     imem address width (DEPTH = 2**AW words)
//  START_CYC   2      cycles core_start is held high after last word written (>=1)
//  MAX_RUN     16'hFFFF  run-cycle limit before timeout error
// PORTS
//  CLK         in   1      clock, posedge
//  reset_n     in   1      asynchronous active-low reset
//  load_go     in   1      pulse: begin a new load (IDLE/DONE/ERROR only)
//  in_valid    in   1      stream word valid
//  in_ready    out  1      loader accepts word this cycle
//  in_data     in   IW     instruction word
//  in_last     in   1      marks final word of program
//  imem_we     out  1      imem write strobe (registered)
//  imem_addr   out  AW     imem write address (registered)
//  imem_wdata  out  IW     imem write data (registered)
//  core_start  out  1      to TopLevel start; high = core held in init
//  core_halt   in   1      from TopLevel halt
//  busy        out  1      state in LOAD/START/RUN
//  done        out  1      program ran to halt
//  err_ovf     out  1      sticky: image exceeded DEPTH
//  err_tmo     out  1      sticky: run exceeded MAX_RUN
//  word_count  out  AW+1   words written in current load
//  run_cycles  out  16     cycles from core_start fall to halt seen
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; core_start=1; in_ready=0; imem_we=0;
//   imem_addr=0; imem_wdata=0; done=0; err_*=0; word_count=0; run_cycles=0.
//  States: IDLE, LOAD, START, RUN, DONE, ERROR (enum in package).
//  IDLE/DONE/ERROR --load_go--> LOAD: clears word_count, run_cycles, done, err_*;
//   write pointer=0. load_go ignored in LOAD/START/RUN.
//  LOAD: in_ready=1 (combinational from state). Accept = in_valid & in_ready.
//   Accept at pointer p -> next cycle imem_we=1, imem_addr=p, imem_wdata=in_data;
//   p++, word_count++. One-cycle write latency; back-to-back accepts sustain 1 word/clk.
//   in_last accepted -> START. Accept at p=DEPTH-1 without in_last -> word written,
//   err_ovf=1, -> ERROR. Accept at p=DEPTH-1 with in_last -> START (exact fit legal).
//  START: core_start=1, in_ready=0; counter runs START_CYC cycles (covers final
//   imem write), then -> RUN.
//  RUN: core_start=0; run_cycles increments every cycle (saturating at MAX_RUN).
//   core_halt sampled only in RUN, ignored on the first RUN cycle (core still
//   leaving init). core_halt=1 -> DONE. run_cycles==MAX_RUN without halt ->
//   err_tmo=1, -> ERROR. Halt and limit same cycle: halt wins (DONE).
//  DONE: done=1, core_start=0 (core stays halted, state inspectable).
//  ERROR: core_start=1, in_ready=0, done=0; err flags held until next load_go.
//  in_valid while not in LOAD: not accepted, no side effects.
//  imem_we is 0 in every cycle not following an accept. core_start high in
//   IDLE/LOAD/START/ERROR, low in RUN/DONE. busy=1 in LOAD/START/RUN.
//  reset_n asserted mid-LOAD or mid-RUN: immediate return to reset values; partial
//   image in imem is not erased.
// STRUCTURE
//  loader_pkg: state_t enum {IDLE,LOAD,START,RUN,DONE,ERROR}, default IW/AW
//   constants shared with TopLevel's instruction memory.
//  Single module; no sub-module (FSM + pointer + two counters).
// TESTING
//  1 Reset, load_go, stream 5 words 0x1A0..0x1A4, last on 5th -> imem_we at addrs
//    0..4 one cycle after each accept, word_count=5, core_start low 2 cycles later.
//  2 in_valid toggling 1/0 during LOAD -> writes only on accepted cycles, addrs gapless.
//  3 AW=3, stream 9 words no last -> 8 writes, err_ovf=1 after 8th, in_ready=0,
//    core_start=1; 8 words with last on 8th -> START, no error.
//  4 Core model raises halt 20 cycles after start falls -> done=1, run_cycles=20.
//  5 MAX_RUN=50, halt never -> err_tmo=1 at run_cycles=50, core_start=1; halt on
//    cycle 50 instead -> done=1, err_tmo=0.
//  6 reset_n low during RUN -> core_start=1, done=0, counters 0 same cycle; then
//    load_go reloads cleanly from addr 0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader and the core's instruction
// memory: default word/address widths and the loader state encoding.
package loader_pkg;
  localparam int IW_DEF = 9;   // instruction word width
  localparam int AW_DEF = 10;  // imem address width

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    DONE,
    ERROR
  } state_t;
endpackage

// File: rtl/inst_loader_if.sv
// Instruction word stream (valid/ready) from the host link to the loader.
//   in_valid : word valid          (master -> slave)
//   in_data  : instruction word    (master -> slave)
//   in_last  : final program word  (master -> slave)
//   in_ready : loader accepts word (slave -> master)
interface inst_loader_if
  import loader_pkg::*;
#(
  parameter int IW = IW_DEF
) ();
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [IW-1:0] in_data;

  modport master (output in_valid, in_data, in_last, input in_ready);
  modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/inst_loader.sv
// Instruction memory writer: streams words into imem from address 0, then
// releases core_start, times the run until core_halt and reports done/error.
// Ports:
//   CLK, reset_n          clock (posedge), async active-low reset
//   load_go               start a new load (honoured in IDLE/DONE/ERROR)
//   s_in                  instruction stream (inst_loader_if.slave)
//   imem_we/addr/wdata    registered imem write port, one cycle after accept
//   core_start            high holds the core in init
//   core_halt             core has halted
//   busy, done            status
//   err_ovf, err_tmo      sticky errors: image overflow, run timeout
//   word_count            words written in current load
//   run_cycles            cycles from core_start fall to halt
module inst_loader
  import loader_pkg::*;
#(
  parameter int          IW        = IW_DEF,
  parameter int          AW        = AW_DEF,
  parameter int          START_CYC = 2,
  parameter logic [15:0] MAX_RUN   = 16'hFFFF
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          load_go,
  inst_loader_if.slave  s_in,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [IW-1:0] imem_wdata,
  output logic          core_start,
  input  logic          core_halt,
  output logic          busy,
  output logic          done,
  output logic          err_ovf,
  output logic          err_tmo,
  output logic [AW:0]   word_count,
  output logic [15:0]   run_cycles
);

  localparam int               SCW        = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam logic [SCW-1:0]   START_LAST = SCW'(START_CYC - 1);
  localparam logic [AW-1:0]    PTR_MAX    = {AW{1'b1}};

  state_t         state_q, state_d;
  logic [AW-1:0]  ptr_q, ptr_d;
  logic [AW:0]    wcnt_q, wcnt_d;
  logic [15:0]    run_q, run_d;
  logic [SCW-1:0] scnt_q, scnt_d;
  logic           ovf_q, ovf_d;
  logic           tmo_q, tmo_d;
  logic           we_q, we_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [IW-1:0]  wdata_q, wdata_d;
  logic           accept;

  assign s_in.in_ready = (state_q == LOAD);
  assign accept        = s_in.in_valid && (state_q == LOAD);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wcnt_d  = wcnt_q;
    run_d   = run_q;
    scnt_d  = scnt_q;
    ovf_d   = ovf_q;
    tmo_d   = tmo_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (load_go) begin
          state_d = LOAD;
          ptr_d   = '0;
          wcnt_d  = '0;
          run_d   = '0;
          ovf_d   = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = s_in.in_data;
          ptr_d   = ptr_q + AW'(1);
          wcnt_d  = wcnt_q + (AW+1)'(1);
          if (s_in.in_last) begin
            // exact fit at the top address is legal
            state_d = START;
            scnt_d  = '0;
          end else if (ptr_q == PTR_MAX) begin
            ovf_d   = 1'b1;
            state_d = ERROR;
          end
        end
      end
      START: begin
        // hold core in init long enough for the final write to land
        if (scnt_q == START_LAST) state_d = RUN;
        else                      scnt_d  = scnt_q + SCW'(1);
      end
      RUN: begin
        // run_q is zero only on the first RUN cycle: core still leaving init,
        // so a halt seen there is stale. Halt beats timeout.
        if (core_halt && (run_q != 16'd0)) begin
          state_d = DONE;
        end else if (run_q == MAX_RUN) begin
          tmo_d   = 1'b1;
          state_d = ERROR;
        end else begin
          run_d = run_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      wcnt_q  <= '0;
      run_q   <= '0;
      scnt_q  <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wcnt_q  <= wcnt_d;
      run_q   <= run_d;
      scnt_q  <= scnt_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_start = (state_q == IDLE) || (state_q == LOAD) ||
                      (state_q == START) || (state_q == ERROR);
  assign busy       = (state_q == LOAD) || (state_q == START) || (state_q == RUN);
  assign done       = (state_q == DONE);
  assign err_ovf    = ovf_q;
  assign err_tmo    = tmo_q;
  assign word_count = wcnt_q;
  assign run_cycles = run_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader (AW=3, MAX_RUN=50): expected imem writes are
// queued when a word is driven and popped when imem_we appears.
module tb_inst_loader;
  import loader_pkg::*;

  localparam int          IW = 9;
  localparam int          AW = 3;
  localparam int          SC = 2;
  localparam logic [15:0] MR = 16'd50;

  logic          CLK = 1'b0;
  logic          reset_n = 1'b0;
  logic          load_go = 1'b0;
  logic          core_halt = 1'b0;
  logic          imem_we, core_start, busy, done, err_ovf, err_tmo;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_wdata;
  logic [AW:0]   word_count;
  logic [15:0]   run_cycles;

  inst_loader_if #(.IW(IW)) vif ();

  inst_loader #(.IW(IW), .AW(AW), .START_CYC(SC), .MAX_RUN(MR)) dut (
    .CLK        (CLK),
    .reset_n    (reset_n),
    .load_go    (load_go),
    .s_in       (vif.slave),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_start (core_start),
    .core_halt  (core_halt),
    .busy       (busy),
    .done       (done),
    .err_ovf    (err_ovf),
    .err_tmo    (err_tmo),
    .word_count (word_count),
    .run_cycles (run_cycles)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];
  int  passed = 0;
  int  total  = 0;
  int  cyc    = 0;
  int  wptr   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // advance one clock; sample #1 after the edge and score any imem write
  task automatic tick();
    wr_t e;
    @(posedge CLK);
    #1;
    cyc++;
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", imem_we, 0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", imem_addr, e.addr);
        check("wr_data", imem_wdata, e.data);
        check("wr_cycle", cyc, e.cyc);
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      check("missing_we", imem_we, 1);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic send(input logic [IW-1:0] d, input logic l, input logic rdy_exp);
    vif.in_valid = 1'b1;
    vif.in_data  = d;
    vif.in_last  = l;
    check("in_ready", vif.in_ready, rdy_exp);
    if (rdy_exp) begin
      exp_q.push_back('{addr: wptr, data: d, cyc: cyc + 1});
      wptr++;
    end
    tick();
    vif.in_valid = 1'b0;
    vif.in_last  = 1'b0;
  endtask

  task automatic go();
    load_go = 1'b1;
    tick();
    load_go = 1'b0;
    wptr    = 0;
  endtask

  initial begin
    vif.in_valid = 1'b0;
    vif.in_data  = '0;
    vif.in_last  = 1'b0;

    // reset state
    tick();
    check("rst_core_start", core_start, 1);
    check("rst_in_ready", vif.in_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_done", done, 0);
    check("rst_ovf", err_ovf, 0);
    check("rst_tmo", err_tmo, 0);
    check("rst_wcnt", word_count, 0);
    check("rst_run", run_cycles, 0);
    check("rst_busy", busy, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // 5-word load, back-to-back
    go();
    check("t1_busy", busy, 1);
    for (int i = 0; i < 5; i++) send(IW'(9'h1A0 + i), (i == 4), 1'b1);
    check("t1_wcnt", word_count, 5);
    check("t1_start0", core_start, 1);
    check("t1_rdy_start", vif.in_ready, 0);
    tick();
    check("t1_start1", core_start, 1);
    tick();
    check("t1_start_fall", core_start, 0);
    check("t1_run0", run_cycles, 0);

    // halt 20 cycles after start falls
    repeat (20) tick();
    check("t4_run20", run_cycles, 20);
    check("t4_not_done", done, 0);
    core_halt = 1'b1;
    tick();
    core_halt = 1'b0;
    check("t4_done", done, 1);
    check("t4_run_cycles", run_cycles, 20);
    check("t4_core_start", core_start, 0);
    check("t4_busy", busy, 0);

    // toggling in_valid; load_go ignored during RUN
    go();
    check("t2_done_clr", done, 0);
    check("t2_wcnt_clr", word_count, 0);
    check("t2_run_clr", run_cycles, 0);
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) send(IW'(9'h0C0 + i), (i == 4), 1'b1);
      else begin
        vif.in_valid = 1'b0;
        vif.in_data  = '1;
        tick();
      end
    end
    check("t2_wcnt", word_count, 3);
    repeat (4) tick();
    load_go = 1'b1;
    tick();
    load_go = 1'b0;
    check("t2_go_ignored_busy", busy, 1);
    check("t2_go_ignored_cs", core_start, 0);
    check("t2_run3", run_cycles, 3);
    check("t2_wcnt_kept", word_count, 3);
    core_halt = 1'b1;
    tick();
    core_halt = 1'b0;
    check("t2_done", done, 1);

    // overflow: 8 words without last, then a 9th refused
    go();
    for (int i = 0; i < 8; i++) send(IW'(9'h100 + i), 1'b0, 1'b1);
    check("t3_ovf", err_ovf, 1);
    check("t3_rdy", vif.in_ready, 0);
    check("t3_cs", core_start, 1);
    check("t3_busy", busy, 0);
    check("t3_wcnt", word_count, 8);
    check("t3_done", done, 0);
    send(9'h1FF, 1'b0, 1'b0);
    check("t3_wcnt_hold", word_count, 8);
    check("t3_ovf_hold", err_ovf, 1);

    // exact fit: 8 words, last on 8th
    go();
    check("t3_ovf_clr", err_ovf, 0);
    for (int i = 0; i < 8; i++) send(IW'(9'h140 + i), (i == 7), 1'b1);
    check("t3_fit_ovf", err_ovf, 0);
    check("t3_fit_busy", busy, 1);
    check("t3_fit_cs", core_start, 1);
    check("t3_fit_wcnt", word_count, 8);
    tick();
    tick();
    check("t3_fit_run", core_start, 0);

    // halt on first RUN cycle ignored, then timeout
    core_halt = 1'b1;
    tick();
    core_halt = 1'b0;
    check("t5_halt0_ignored", busy, 1);
    check("t5_halt0_done", done, 0);
    check("t5_run1", run_cycles, 1);
    repeat (49) tick();
    check("t5_run50", run_cycles, 50);
    check("t5_tmo_pre", err_tmo, 0);
    tick();
    check("t5_tmo", err_tmo, 1);
    check("t5_tmo_cs", core_start, 1);
    check("t5_tmo_done", done, 0);
    check("t5_tmo_run", run_cycles, 50);

    // halt exactly at the limit wins
    go();
    check("t5_tmo_clr", err_tmo, 0);
    check("t5_run_clr", run_cycles, 0);
    send(9'h011, 1'b0, 1'b1);
    send(9'h012, 1'b1, 1'b1);
    repeat (52) tick();
    check("t5b_run50", run_cycles, 50);
    core_halt = 1'b1;
    tick();
    core_halt = 1'b0;
    check("t5b_done", done, 1);
    check("t5b_tmo", err_tmo, 0);
    check("t5b_run", run_cycles, 50);
    check("t5b_cs", core_start, 0);

    // reset mid-RUN, then clean reload
    go();
    send(9'h050, 1'b0, 1'b1);
    send(9'h051, 1'b0, 1'b1);
    send(9'h052, 1'b1, 1'b1);
    repeat (7) tick();
    check("t6_run5", run_cycles, 5);
    reset_n = 1'b0;
    #1;
    check("t6_rst_cs", core_start, 1);
    check("t6_rst_done", done, 0);
    check("t6_rst_run", run_cycles, 0);
    check("t6_rst_wcnt", word_count, 0);
    check("t6_rst_busy", busy, 0);
    tick();
    reset_n = 1'b1;
    tick();
    go();
    send(9'h0AA, 1'b0, 1'b1);
    send(9'h0AB, 1'b1, 1'b1);
    check("t6_wcnt", word_count, 2);
    tick();
    tick();
    check("t6_run", core_start, 0);
    tick();
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
